// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one multi-cycle backing-memory port between the instruction-cache
// line-refill port (I, LINE_WORDS-beat bursts) and the CPU load/store port
// (D, single words with byte enables). Ties are resolved round-robin against
// the last grant. A watchdog aborts an access whose mem_ack never arrives and
// reports the abort through err on the owner's done/ack pulse.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_req, i_addr         refill request (held until i_done) and line address
//   i_rdata, i_rvalid     refill word and its one-cycle valid strobe
//   i_done                burst complete (or aborted, with err)
//   d_req, d_we, d_addr,
//   d_wdata, d_be         data request (held until d_ack); latched on grant
//   d_rdata, d_ack        read data and access-complete pulse
//   err                   qualifies i_done/d_ack: access aborted by timeout
//   mem_req, mem_we,
//   mem_addr, mem_wdata,
//   mem_be                memory request side (word-aligned address)
//   mem_rdata, mem_ack    memory response; ack completes the current word
//   busy                  an access is in progress
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_rvalid,
    output logic                    i_done,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,

    output logic                    err,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,

    output logic                    busy
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BEAT_W   = $clog2(LINE_WORDS);
    localparam int unsigned TO_BITS  = $clog2(TIMEOUT + 1);
    localparam int unsigned WAIT_W   = (TO_BITS > 8) ? TO_BITS : 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_I_BURST  = 2'd1,
        S_D_ACCESS = 2'd2
    } state_t;

    state_t                  state_q,      state_d;
    logic                    last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]       beat_q,       beat_d;
    logic [WAIT_W-1:0]       wait_cnt_q,   wait_cnt_d;
    logic                    d_we_q,       d_we_d;
    logic [ADDR_WIDTH-1:0]   d_addr_q,     d_addr_d;
    logic [DATA_WIDTH-1:0]   d_wdata_q,    d_wdata_d;
    logic [BE_WIDTH-1:0]     d_be_q,       d_be_d;

    // Sub-word address bits carry no information for either requester.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[BEAT_W+1:0], d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_I;
            beat_q       <= '0;
            wait_cnt_q   <= '0;
            d_we_q       <= 1'b0;
            d_addr_q     <= '0;
            d_wdata_q    <= '0;
            d_be_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            wait_cnt_q   <= wait_cnt_d;
            d_we_q       <= d_we_d;
            d_addr_q     <= d_addr_d;
            d_wdata_q    <= d_wdata_d;
            d_be_q       <= d_be_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        wait_cnt_d   = wait_cnt_q;
        d_we_d       = d_we_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_be_d       = d_be_q;

        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rdata   = '0;
        d_ack     = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Every completion returns here, so grants are always
                // separated by at least one IDLE cycle. On a tie the port
                // that did not win last time is served.
                if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
                    state_d      = S_I_BURST;
                    last_grant_d = GRANT_I;
                    beat_d       = '0;
                    wait_cnt_d   = '0;
                end else if (d_req) begin
                    state_d      = S_D_ACCESS;
                    last_grant_d = GRANT_D;
                    beat_d       = '0;
                    wait_cnt_d   = '0;
                    d_we_d       = d_we;
                    d_addr_d     = {d_addr[ADDR_WIDTH-1:2], 2'b00};
                    d_wdata_d    = d_wdata;
                    d_be_d       = d_be;
                end
            end

            S_I_BURST: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_be   = '1;
                mem_addr = {i_addr[ADDR_WIDTH-1:BEAT_W+2], beat_q, 2'b00};
                if (mem_ack) begin
                    i_rvalid   = 1'b1;
                    i_rdata    = mem_rdata;
                    wait_cnt_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        i_done  = 1'b1;
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    // Abandon the remaining beats; an ack in this same cycle
                    // would have taken the branch above instead.
                    i_done     = 1'b1;
                    err        = 1'b1;
                    beat_d     = '0;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_D_ACCESS: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = d_we_q;
                mem_addr  = d_addr_q;
                mem_wdata = d_wdata_q;
                mem_be    = d_we_q ? d_be_q : '1;
                if (mem_ack) begin
                    d_ack      = 1'b1;
                    d_rdata    = mem_rdata;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    d_ack      = 1'b1;
                    err        = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (LINE_WORDS=4, TIMEOUT=8).
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// Per-cycle port expectations live in a vector table; completion events
// (i_rvalid / i_done / d_ack) are pushed to a scoreboard queue as the
// stimulus row is driven and popped when the DUT raises them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINE_WORDS(4),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_rvalid (i_rvalid),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy)
    );

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        // expected port state
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_chkwd;
        logic        e_all0;
        // expected completion event
        logic        e_ev;
        logic        e_rv;
        logic [31:0] e_irdata;
        logic        e_idone;
        logic        e_dack;
        logic [31:0] e_drdata;
        logic        e_chkd;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        rv;
        logic [31:0] irdata;
        logic        idone;
        logic        dack;
        logic [31:0] drdata;
        logic        chkd;
    } ev_t;

    vec_t tbl[$];
    vec_t v;
    ev_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t clr(vec_t x);
        x.e_req = 0; x.e_addr = 0; x.e_we = 0; x.e_be = 0; x.e_wdata = 0;
        x.e_chkwd = 0; x.e_all0 = 0; x.e_ev = 0; x.e_rv = 0; x.e_irdata = 0;
        x.e_idone = 0; x.e_dack = 0; x.e_drdata = 0; x.e_chkd = 0;
        return x;
    endfunction

    function automatic vec_t idle(vec_t x, logic all0);
        x = clr(x);
        x.e_all0 = all0;
        return x;
    endfunction

    function automatic vec_t dst(vec_t x, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        x = clr(x);
        x.e_req = 1; x.e_addr = a; x.e_we = we; x.e_be = be; x.e_wdata = wd; x.e_chkwd = we;
        return x;
    endfunction

    function automatic vec_t ist(vec_t x, logic [31:0] a);
        x = clr(x);
        x.e_req = 1; x.e_addr = a; x.e_we = 0; x.e_be = 4'hF;
        return x;
    endfunction

    function automatic vec_t iev(vec_t x, logic [31:0] d, logic done);
        x.e_ev = 1; x.e_rv = 1; x.e_irdata = d; x.e_idone = done;
        return x;
    endfunction

    function automatic vec_t dev(vec_t x, logic [31:0] d, logic chkd);
        x.e_ev = 1; x.e_dack = 1; x.e_drdata = d; x.e_chkd = chkd;
        return x;
    endfunction

    // Full burst acked every cycle; line base is `base`, data base+beat.
    task automatic add_burst(input logic [31:0] base, input logic [31:0] dbase);
        for (int b = 0; b < 4; b++) begin
            v.mem_ack   = 1;
            v.mem_rdata = dbase + 32'(b);
            tbl.push_back(iev(ist(v, base + 32'(4 * b)), dbase + 32'(b), b == 3));
        end
        v.mem_ack = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        ev_t e;

        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0;

        v = '{default: '0};
        // reset state
        v.rst = 1; tbl.push_back(idle(v, 1));
        v.rst = 0; tbl.push_back(idle(v, 1));
        // lone D write, ack three cycles after d_req; inputs change mid-access
        v.d_req = 1; v.d_we = 1; v.d_addr = 32'h1000_0010; v.d_wdata = 32'hDEAD_BEEF; v.d_be = 4'b0011;
        tbl.push_back(idle(v, 0));
        tbl.push_back(dst(v, 1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011));
        v.d_we = 0; v.d_addr = 32'h2000_0000; v.d_wdata = 32'h0BAD_0BAD; v.d_be = 4'b1100;
        tbl.push_back(dst(v, 1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011));
        v.mem_ack = 1; v.mem_rdata = 32'h7777_7777;
        tbl.push_back(dev(dst(v, 1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011), 32'h0, 0));
        v.mem_ack = 0; v.d_req = 0;
        tbl.push_back(idle(v, 0));
        // tie with last grant = D: I refill at 0x104 wins, D read waits
        v.i_req = 1; v.i_addr = 32'h0000_0104; v.d_req = 1; v.d_we = 0; v.d_addr = 32'h60; v.d_be = 4'h0;
        tbl.push_back(idle(v, 0));
        add_burst(32'h100, 32'h100);
        v.i_req = 0;
        tbl.push_back(idle(v, 0));
        v.mem_ack = 1; v.mem_rdata = 32'h600D_0060;
        tbl.push_back(dev(dst(v, 0, 32'h60, 32'h0, 4'hF), 32'h600D_0060, 1));
        v.mem_ack = 0; v.d_req = 0;
        tbl.push_back(idle(v, 0));
        // tie right after reset goes to D, then I after one IDLE cycle
        v.rst = 1; tbl.push_back(idle(v, 1));
        v.rst = 0; v.i_req = 1; v.i_addr = 32'h200; v.d_req = 1; v.d_we = 0; v.d_addr = 32'h20; v.d_be = 4'b0011;
        tbl.push_back(idle(v, 1));
        v.mem_ack = 1; v.mem_rdata = 32'hCAFE_0001;
        tbl.push_back(dev(dst(v, 0, 32'h20, 32'h0, 4'hF), 32'hCAFE_0001, 1));
        v.mem_ack = 0; v.d_req = 0;
        tbl.push_back(idle(v, 0));
        add_burst(32'h200, 32'hA000_0000);
        v.i_req = 0;
        tbl.push_back(idle(v, 0));
        // tie with last grant = I goes to D
        v.i_req = 1; v.i_addr = 32'h300; v.d_req = 1; v.d_addr = 32'h44;
        tbl.push_back(idle(v, 0));
        v.mem_ack = 1; v.mem_rdata = 32'h55AA_55AA;
        tbl.push_back(dev(dst(v, 0, 32'h44, 32'h0, 4'hF), 32'h55AA_55AA, 1));
        v.mem_ack = 0; v.d_req = 0;
        tbl.push_back(idle(v, 0));
        // reset during beat 2, then the held i_req restarts from the line base
        v.mem_ack = 1; v.mem_rdata = 32'hB0;
        tbl.push_back(iev(ist(v, 32'h300), 32'hB0, 0));
        v.mem_rdata = 32'hB1;
        tbl.push_back(iev(ist(v, 32'h304), 32'hB1, 0));
        v.mem_ack = 0; v.rst = 1;
        tbl.push_back(ist(v, 32'h308));
        v.rst = 0;
        tbl.push_back(idle(v, 1));
        add_burst(32'h300, 32'hC0);
        v.i_req = 0;
        tbl.push_back(idle(v, 0));
        // spurious acks in IDLE
        v.mem_ack = 1; v.mem_rdata = 32'h1234_5678;
        tbl.push_back(idle(v, 0));
        tbl.push_back(idle(v, 0));
        v.mem_ack = 0;
        tbl.push_back(idle(v, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst = tbl[k].rst; i_req = tbl[k].i_req; i_addr = tbl[k].i_addr;
            d_req = tbl[k].d_req; d_we = tbl[k].d_we; d_addr = tbl[k].d_addr;
            d_wdata = tbl[k].d_wdata; d_be = tbl[k].d_be;
            mem_ack = tbl[k].mem_ack; mem_rdata = tbl[k].mem_rdata;
            if (tbl[k].e_ev) begin
                e.cyc = k; e.rv = tbl[k].e_rv; e.irdata = tbl[k].e_irdata;
                e.idone = tbl[k].e_idone; e.dack = tbl[k].e_dack;
                e.drdata = tbl[k].e_drdata; e.chkd = tbl[k].e_chkd;
                sb.push_back(e);
            end
            #1;
            chk($sformatf("mem_req[%0d]", k), 32'(mem_req), 32'(tbl[k].e_req));
            chk($sformatf("busy[%0d]", k), 32'(busy), 32'(tbl[k].e_req));
            if (tbl[k].e_req) begin
                chk($sformatf("mem_addr[%0d]", k), mem_addr, tbl[k].e_addr);
                chk($sformatf("mem_we[%0d]", k), 32'(mem_we), 32'(tbl[k].e_we));
                chk($sformatf("mem_be[%0d]", k), 32'(mem_be), 32'(tbl[k].e_be));
                if (tbl[k].e_chkwd)
                    chk($sformatf("mem_wdata[%0d]", k), mem_wdata, tbl[k].e_wdata);
            end
            if (tbl[k].e_all0)
                chk($sformatf("all_zero[%0d]", k), 32'(mem_we) | mem_addr | mem_wdata | 32'(mem_be), 32'h0);
            if (i_rvalid || i_done || d_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event[%0d]: rvalid=%0b done=%0b ack=%0b, none expected",
                             k, i_rvalid, i_done, d_ack);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("event_cycle[%0d]", k), 32'(k), 32'(e.cyc));
                    chk($sformatf("i_rvalid[%0d]", k), 32'(i_rvalid), 32'(e.rv));
                    if (e.rv) chk($sformatf("i_rdata[%0d]", k), i_rdata, e.irdata);
                    chk($sformatf("i_done[%0d]", k), 32'(i_done), 32'(e.idone));
                    chk($sformatf("d_ack[%0d]", k), 32'(d_ack), 32'(e.dack));
                    chk($sformatf("err[%0d]", k), 32'(err), 32'h0);
                    if (e.chkd) chk($sformatf("d_rdata[%0d]", k), d_rdata, e.drdata);
                end
            end else begin
                chk($sformatf("quiet[%0d]", k), i_rdata | d_rdata | 32'(err), 32'h0);
            end
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        // D watchdog: memory never acks
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h5A5A_5A5A; d_be = 4'hF;
        mem_ack = 0; mem_rdata = 32'hFFFF_FFFF;
        #1 chk("wd_d_idle", 32'(mem_req), 32'h0);
        @(negedge clk);
        #1 chk("wd_d_req_rise", 32'(mem_req), 32'h1);
        n = 0;
        while (!d_ack && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        chk("wd_d_latency", 32'(n), 32'd8);
        chk("wd_d_err", 32'(err), 32'h1);
        chk("wd_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        d_req = 0;
        #1 chk("wd_d_req_drop", 32'(mem_req), 32'h0);
        chk("wd_d_ack_single", 32'(d_ack), 32'h0);

        // I watchdog: burst abandoned at beat 0, no i_rvalid
        @(negedge clk);
        i_req = 1; i_addr = 32'h400;
        #1 chk("wd_i_idle", 32'(mem_req), 32'h0);
        @(negedge clk);
        #1 chk("wd_i_addr", mem_addr, 32'h400);
        n = 0;
        while (!i_done && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        chk("wd_i_latency", 32'(n), 32'd8);
        chk("wd_i_err", 32'(err), 32'h1);
        chk("wd_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("wd_i_rdata", i_rdata, 32'h0);
        @(negedge clk);
        i_req = 0;
        #1 chk("wd_i_busy_drop", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle backing-memory port between two requesters: the instruction-cache line-refill port (I) and the CPU load/store data port (D).
- I requests are burst line refills of LINE_WORDS words. D requests are single-word reads or writes with byte enables.
- Arbitration is round-robin. A watchdog aborts any access whose memory acknowledge never arrives.
- Sits between icache/CPU and the memory-side wrapper, replacing today's direct wiring.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (byte enables are DATA_WIDTH/8 = 4).
- LINE_WORDS, 4, words per I burst; power of 2, ≥2.
- TIMEOUT, 255, cycles without mem_ack before abort; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  refill request; held high until i_done
- i_addr  in  32  refill address; low log2(LINE_WORDS)+2 bits ignored
- i_rdata  out  32  refill word
- i_rvalid  out  1  i_rdata valid, one pulse per word
- i_done  out  1  burst complete pulse
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write
- d_addr  in  32  byte address (word-aligned)
- d_wdata  in  32  write data
- d_be  in  4  write byte enables
- d_rdata  out  32  read data
- d_ack  out  1  access complete pulse
- err  out  1  qualifies i_done/d_ack: access aborted by timeout
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completes current word
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, I_BURST, D_ACCESS. Registers: state, last_grant (0=I, 1=D), beat (log2 LINE_WORDS bits), wait_cnt (8 bits min), latched address and write data for D.
- Reset:
  - Registers: state=IDLE, last_grant=I, beat=0, wait_cnt=0.
  - Outputs: all 0 (including mem_req, i_rvalid, i_done, d_ack, err, busy).
- Arbitration in IDLE, evaluated each cycle:
  - Only i_req → I_BURST.
  - Only d_req → D_ACCESS.
  - Both → grant the port not equal to last_grant. After reset, the first tie goes to D.
  - On grant: last_grant updates, D inputs are latched, beat=0, wait_cnt=0.
- mem_req is asserted from the first cycle in I_BURST/D_ACCESS, so the minimum request-to-mem_req latency is 1 cycle.
- I_BURST:
  - mem_we=0, mem_be=4'hF.
  - mem_addr = {i_addr[31:log2(LINE_WORDS)+2], beat, 2'b00}.
  - On mem_ack: i_rvalid=1 and i_rdata=mem_rdata, combinationally in the same cycle; beat increments; wait_cnt clears.
  - On the ack with beat==LINE_WORDS-1: also i_done=1, beat wraps to 0, next state IDLE.
- D_ACCESS:
  - mem_we, mem_addr ({d_addr[31:2],2'b00}), mem_wdata and mem_be come from the latched D values. mem_be is forced to 4'hF on reads.
  - On mem_ack: d_ack=1 and d_rdata=mem_rdata (d_rdata don't-care for writes); next state IDLE.
- After every completion, IDLE is held for at least 1 cycle; back-to-back grants are not allowed. The requester must drop its req in the cycle after i_done/d_ack.
- Watchdog:
  - wait_cnt increments on each granted cycle without mem_ack.
  - When wait_cnt reaches TIMEOUT without an ack, that cycle pulses the owner's i_done or d_ack with err=1 and rdata=0 (no i_rvalid). mem_req drops and the state goes to IDLE; remaining I beats are abandoned.
- mem_ack in IDLE is ignored and produces no output pulse.
- Requester inputs changing mid-access are ignored for D (latched). For I, i_addr must be held stable.
- rst asserted mid-burst: next cycle is IDLE with mem_req=0. No done/ack pulse is produced for the killed access.
- Outputs i_rdata/d_rdata hold 0 when their valid/ack is low.

Test Plan:
- Lone D write:
  - Stimulus: d_req, d_we=1, addr 0x1000_0010, wdata 0xDEADBEEF, be 4'b0011; mem_ack 3 cycles later.
  - Required: mem_req high 1 cycle after d_req with those exact values; d_ack single pulse, err=0.
- Lone I refill:
  - Stimulus: i_addr 0x0000_0104; mem_ack every cycle with rdata = addr.
  - Required: mem_addr sequence 0x100, 0x104, 0x108, 0x10C; i_rvalid 4 pulses with matching data; i_done on the 4th.
- Simultaneous i_req/d_req after reset:
  - Required: D granted first, then I after the mandatory IDLE cycle.
  - Repeat the tie: I and D alternate.
- Memory never acks with TIMEOUT=8:
  - Required: d_ack with err=1 exactly 8 granted cycles after mem_req rises; mem_req low the next cycle.
- rst pulsed during beat 2 of an I burst:
  - Required: next cycle mem_req=0, busy=0, no i_done.
  - A fresh i_req then restarts at beat 0 (mem_addr = line base).
- Spurious mem_ack in IDLE:
  - Required: no i_rvalid/d_ack; state stays IDLE.
